// File: rtl/uart_alu_pkg.sv
// Shared types for the TX response path: FSM state encoding, source ids and the arbitration helper.
package uart_alu_pkg;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_CHK} resp_state_e;

  localparam logic SRC_RF  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

  // Round-robin pick: with both sources pending, the one not served last wins.
  function automatic logic pick_src(input logic rf_pend, input logic alu_pend, input logic last);
    if (rf_pend && alu_pend) return ~last;
    return alu_pend ? SRC_ALU : SRC_RF;
  endfunction

endpackage

// File: rtl/resp_slot.sv
// One-entry pending slot for a response source; a capture that lands on an occupied,
// ungranted slot is refused and reported through the drop pulse.
module resp_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] data,
  input  logic         grant,
  output logic         pending,
  output logic [W-1:0] q,
  output logic         drop
);

  assign drop = vld && pending && !grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      q       <= '0;
    end else if (vld && !drop) begin
      q       <= data;
      pending <= 1'b1;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_resp_arbiter.sv
// Round-robin serialiser of RF read data and ALU results into the TX FIFO (ALU LSB byte first).
// Optional trailing XOR checksum byte per response when RESP_CHKSUM_EN is defined.
module tx_resp_arbiter
  import uart_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ALU_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_vld,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_out_vld,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_inc,
  output logic              busy,
  output logic              ovf_err,
  input  logic              ovf_clr
);

`ifdef RESP_CHKSUM_EN
  localparam resp_state_e AFTER_DATA = SEND_CHK;
`else
  localparam resp_state_e AFTER_DATA = IDLE;
`endif

  resp_state_e       state, state_nxt;
  logic              src, last_grant;
  logic [ALU_W-1:0]  hold_reg;
  logic              grant_any, grant_src, rf_grant, alu_grant;
  logic              rf_pend, alu_pend, rf_drop, alu_drop;
  logic [DATA_W-1:0] rf_q;
  logic [ALU_W-1:0]  alu_q;

  resp_slot #(.W(DATA_W)) u_rf_slot (
    .clk(clk), .rst(rst), .vld(rd_data_vld), .data(rd_data), .grant(rf_grant),
    .pending(rf_pend), .q(rf_q), .drop(rf_drop)
  );

  resp_slot #(.W(ALU_W)) u_alu_slot (
    .clk(clk), .rst(rst), .vld(alu_out_vld), .data(alu_out), .grant(alu_grant),
    .pending(alu_pend), .q(alu_q), .drop(alu_drop)
  );

`ifdef RESP_CHKSUM_EN
  logic [DATA_W-1:0] chk_acc;
`endif

  assign rf_grant  = grant_any && (grant_src == SRC_RF);
  assign alu_grant = grant_any && (grant_src == SRC_ALU);
  assign busy      = rf_pend || alu_pend || (state != IDLE);

  always_comb begin
    state_nxt    = state;
    grant_any    = 1'b0;
    grant_src    = pick_src(rf_pend, alu_pend, last_grant);
    fifo_wr_inc  = (state != IDLE) && !fifo_full;
    fifo_wr_data = '0;
    case (state)
      IDLE: begin
        if (rf_pend || alu_pend) begin
          grant_any = 1'b1;
          state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        fifo_wr_data = hold_reg[DATA_W-1:0];
        if (fifo_wr_inc) state_nxt = (src == SRC_ALU) ? SEND_HI : AFTER_DATA;
      end
      SEND_HI: begin
        fifo_wr_data = hold_reg[ALU_W-1:DATA_W];
        if (fifo_wr_inc) state_nxt = AFTER_DATA;
      end
`ifdef RESP_CHKSUM_EN
      SEND_CHK: begin
        fifo_wr_data = chk_acc;
        if (fifo_wr_inc) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      src        <= SRC_RF;
      last_grant <= SRC_ALU;
      hold_reg   <= '0;
      ovf_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        src        <= grant_src;
        last_grant <= grant_src;
        hold_reg   <= (grant_src == SRC_ALU) ? alu_q : {{(ALU_W-DATA_W){1'b0}}, rf_q};
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (rf_drop || alu_drop) ovf_err <= 1'b1;
      else if (ovf_clr)        ovf_err <= 1'b0;
    end
  end

`ifdef RESP_CHKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_acc <= '0;
    end else if (grant_any) begin
      chk_acc <= '0;
    end else if (fifo_wr_inc && (state == SEND_LO || state == SEND_HI)) begin
      chk_acc <= chk_acc ^ fifo_wr_data;
    end
  end
`endif

endmodule
